// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one iterative binary<->Gray converter among
// NUM_REQ requesters. Each result is held on a valid/ready output port until it is taken.
module gray_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(NUM_REQ)-1:0]   out_id,
  output logic                         out_mode,
  output logic                         busy,
  output logic [1:0]                   dbg_state,
  output logic [$clog2(NUM_REQ)-1:0]   dbg_rr_ptr
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int KW  = $clog2(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. req_ready is one-hot or zero and only asserted in IDLE, out of reset.
  // Once valid is raised, the payload holds until that transfer. valid never waits on ready.
  typedef enum logic [1:0] {IDLE = 2'd0, B2G = 2'd1, G2B = 2'd2, OUT = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q;
  logic [WIDTH-1:0]   op_q;
  logic               mode_q;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [KW-1:0]      k_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     idx;
  logic               found;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_mode;
  logic [IDW-1:0]     next_ptr;
  logic               accept;

  // Search from rr_ptr upward with wrap. The first valid request wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = IDW'((int'(rr_ptr_q) + j) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_mode = req_mode[i];
      end
    end
  end

  assign next_ptr = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
  assign accept   = (state_q == IDLE) && found;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = sel_mode ? G2B : B2G;
      B2G:     state_d = OUT;
      G2B:     if (k_q == '0) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = ((state_q == IDLE) && !rst) ? grant : '0;
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  // Gray->binary resolves one bit per cycle from the MSB down. The MSB is seeded at accept.
  always_comb begin
    res_d = res_q;
    case (state_q)
      IDLE: begin
        if (found && sel_mode) begin
          res_d            = '0;
          res_d[WIDTH-1]   = sel_data[WIDTH-1];
        end
      end
      B2G: res_d = op_q ^ (op_q >> 1);
      G2B: begin
        for (int i = 0; i < WIDTH-1; i++) begin
          if (KW'(i) == k_q) res_d[i] = res_q[i+1] ^ op_q[i];
        end
      end
      default: res_d = res_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      op_q     <= '0;
      mode_q   <= 1'b0;
      id_q     <= '0;
      res_q    <= '0;
      k_q      <= '0;
      out_data <= '0;
      out_id   <= '0;
      out_mode <= 1'b0;
    end else begin
      res_q <= res_d;
      if (accept) begin
        op_q     <= sel_data;
        mode_q   <= sel_mode;
        id_q     <= grant_id;
        rr_ptr_q <= next_ptr;
        k_q      <= KW'(WIDTH-2);
      end else if (state_q == G2B && k_q != '0) begin
        k_q <= k_q - 1'b1;
      end
      // Output registers load only when entering OUT, so they hold through IDLE and the next conversion.
      if (state_d == OUT && state_q != OUT) begin
        out_data <= res_d;
        out_id   <= id_q;
        out_mode <= mode_q;
      end
    end
  end

  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed and randomized bench for gray_conv_arbiter. It checks the design against an
// arithmetic code-conversion model, a round-robin pointer model and an expected queue.
module tb_gray_conv_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int IDW     = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_mode;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [IDW-1:0]           out_id;
  logic                     out_mode;
  logic                     busy;
  logic [1:0]               dbg_state;
  logic [IDW-1:0]           dbg_rr_ptr;

  logic [WIDTH-1:0] opnd [NUM_REQ];

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_lat = 0;
  bit pending_lat = 0;
  logic [WIDTH-1:0] last_out;
  logic [WIDTH-1:0] exp_q[$];
  logic [IDW-1:0]   exp_id_q[$];
  logic             exp_mode_q[$];
  logic [WIDTH-1:0] out_log[$];

  gray_conv_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_mode(out_mode), .busy(busy),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = opnd[i];
  end

  function automatic logic [WIDTH-1:0] ref_b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit k is the XOR of all Gray bits at or above k.
  function automatic logic [WIDTH-1:0] ref_g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int s = 0; s < WIDTH; s++) r ^= (g >> s);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_id_q.delete();
    exp_mode_q.delete();
    model_ptr   = 0;
    pending_lat = 0;
  endtask

  // One clock: sample before the rising edge, update the models, then move to the next drive point.
  task automatic cycle();
    int eid;
    logic [IDW-1:0] eidx;
    logic [NUM_REQ-1:0] exp_gnt;
    #1;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    if (out_valid) chk("ready_while_out", 32'(req_ready), 0);
    if (pending_lat && out_valid) begin
      chk("latency", cyc - acc_cyc, acc_lat);
      pending_lat = 0;
    end
    if (req_ready != '0) begin
      eid = -1;
      for (int j = 0; j < NUM_REQ; j++)
        if (eid < 0 && req_valid[IDW'((model_ptr + j) % NUM_REQ)]) eid = (model_ptr + j) % NUM_REQ;
      exp_gnt = (eid < 0) ? '0 : (NUM_REQ'(1) << eid);
      chk("grant", 32'(req_ready), 32'(exp_gnt));
      if (eid >= 0) begin
        eidx = IDW'(eid);
        exp_id_q.push_back(eidx);
        exp_mode_q.push_back(req_mode[eidx]);
        exp_q.push_back(req_mode[eidx] ? ref_g2b(opnd[eidx]) : ref_b2g(opnd[eidx]));
        model_ptr   = (eid + 1) % NUM_REQ;
        acc_cyc     = cyc;
        acc_lat     = req_mode[eidx] ? WIDTH : 2;
        pending_lat = 1;
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 0);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        chk("out_id",   32'(out_id),   32'(exp_id_q.pop_front()));
        chk("out_mode", 32'(out_mode), 32'(exp_mode_q.pop_front()));
      end
      last_out = out_data;
      out_log.push_back(out_data);
    end
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  task automatic do_req(input int r, input logic mode, input logic [WIDTH-1:0] data, input bit rand_ready);
    int n;
    opnd[r]      = data;
    req_mode[r]  = mode;
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[IDW'(r)] && n < 20) begin
      cycle();
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 1);
    cycle();
    req_valid[r] = 1'b0;
    drain(rand_ready);
  endtask

  initial begin
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] t3_exp [4];
    rst       = 1'b1;
    req_valid = '0;
    req_mode  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) opnd[i] = '0;
    @(negedge clk); #1;
    @(negedge clk); #1;

    // Reset state
    chk("rst_state",     32'(dbg_state),  0);
    chk("rst_out_valid", 32'(out_valid),  0);
    chk("rst_out_data",  32'(out_data),   0);
    chk("rst_out_id",    32'(out_id),     0);
    chk("rst_out_mode",  32'(out_mode),   0);
    chk("rst_busy",      32'(busy),       0);
    chk("rst_req_ready", 32'(req_ready),  0);
    chk("rst_rr_ptr",    32'(dbg_rr_ptr), 0);
    rst = 1'b0;
    clear_model();
    out_ready = 1'b1;

    // Binary->Gray from requester 0
    opnd[0] = 4'b1011; req_mode[0] = 1'b0; req_valid[0] = 1'b1;
    #1;
    chk("t1_ready", 32'(req_ready), 32'(4'b0001));
    cycle();
    req_valid[0] = 1'b0;
    chk("t1_busy",      32'(busy),      1);
    chk("t1_state_b2g", 32'(dbg_state), 1);
    chk("t1_no_valid",  32'(out_valid), 0);
    cycle();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data",  32'(out_data),  32'(4'b1110));
    chk("t1_id",    32'(out_id),    0);
    chk("t1_mode",  32'(out_mode),  0);
    cycle();
    chk("t1_idle",      32'(dbg_state),  0);
    chk("t1_valid_low", 32'(out_valid),  0);
    chk("t1_data_hold", 32'(out_data),   32'(4'b1110));
    chk("t1_rr_ptr",    32'(dbg_rr_ptr), 1);

    // Gray->binary from requester 2, three serial cycles
    opnd[2] = 4'b1110; req_mode[2] = 1'b1; req_valid[2] = 1'b1;
    #1;
    chk("t2_ready", 32'(req_ready), 32'(4'b0100));
    cycle();
    req_valid[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t2_g2b_busy",  32'(busy),      1);
      chk("t2_g2b_state", 32'(dbg_state), 2);
      chk("t2_no_valid",  32'(out_valid), 0);
      cycle();
    end
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_data",  32'(out_data),  32'(4'b1011));
    chk("t2_id",    32'(out_id),    2);
    chk("t2_mode",  32'(out_mode),  1);
    cycle();
    chk("t2_idle", 32'(dbg_state), 0);

    // All four requesting from reset: order 0,1,2,3 and pointer wrap
    do_reset();
    out_ready = 1'b1;
    out_log.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      opnd[i] = WIDTH'(i); req_mode[i] = 1'b0;
    end
    req_valid = '1;
    #1;
    for (int gi = 0; gi < NUM_REQ; gi++) begin
      int n;
      n = 0;
      while (req_ready == '0 && n < 20) begin
        cycle();
        n++;
      end
      chk($sformatf("t3_order%0d", gi), 32'(req_ready), 32'(NUM_REQ'(1) << gi));
      cycle();
      req_valid[gi] = 1'b0;
    end
    drain(1'b0);
    t3_exp[0] = 4'b0000; t3_exp[1] = 4'b0001; t3_exp[2] = 4'b0011; t3_exp[3] = 4'b0010;
    chk("t3_out_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      chk($sformatf("t3_out%0d", i), 32'(out_log[i]), 32'(t3_exp[i]));
    chk("t3_rr_wrap", 32'(dbg_rr_ptr), 0);

    // Backpressure with requester 1 pending
    do_reset();
    out_ready = 1'b0;
    opnd[0] = 4'b0101; req_mode[0] = 1'b0; req_valid[0] = 1'b1;
    #1;
    cycle();
    req_valid[0] = 1'b0;
    opnd[1] = 4'b1001; req_mode[1] = 1'b0; req_valid[1] = 1'b1;
    cycle();
    for (int c = 0; c < 5; c++) begin
      chk("t4_valid", 32'(out_valid), 1);
      chk("t4_data",  32'(out_data),  32'(4'b0111));
      chk("t4_id",    32'(out_id),    0);
      chk("t4_ready", 32'(req_ready), 0);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_no_grant_hs", 32'(req_ready), 0);
    cycle();
    chk("t4_ready_after", 32'(req_ready), 32'(4'b0010));
    chk("t4_idle",        32'(dbg_state), 0);
    cycle();
    req_valid[1] = 1'b0;
    drain(1'b0);

    // Reset during the second G2B cycle
    do_reset();
    out_ready = 1'b1;
    opnd[2] = 4'b1001; req_mode[2] = 1'b1; req_valid[2] = 1'b1;
    #1;
    cycle();
    cycle();
    chk("t5_in_g2b", 32'(dbg_state), 2);
    rst = 1'b1;
    cycle();
    chk("t5_state",     32'(dbg_state),  0);
    chk("t5_out_valid", 32'(out_valid),  0);
    chk("t5_busy",      32'(busy),       0);
    chk("t5_rr_ptr",    32'(dbg_rr_ptr), 0);
    clear_model();
    rst = 1'b0;
    #1;
    chk("t5_regrant", 32'(req_ready), 32'(4'b0100));
    cycle();
    req_valid[2] = 1'b0;
    drain(1'b0);

    // Sweep every code in both modes from random requesters, with round trip
    do_reset();
    for (int v = 0; v < (1 << WIDTH); v++) begin
      do_req($urandom_range(0, NUM_REQ-1), 1'b0, WIDTH'(v), 1'b1);
      g = last_out;
      do_req($urandom_range(0, NUM_REQ-1), 1'b1, g, 1'b1);
      chk("roundtrip", 32'(last_out), v);
      do_req($urandom_range(0, NUM_REQ-1), 1'b1, WIDTH'(v), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one iterative binary/Gray code converter among NUM_REQ requesters.
- Each requester asks for binary->Gray or Gray->binary conversion with a valid/ready handshake.
- A round-robin arbiter grants one request at a time. A small FSM sequences the conversion and holds the result on a valid/ready output port until the consumer takes it.
- Sits between the code-conversion datapath and its client blocks.

Parameters:
- NUM_REQ, 4, number of requesters (2..8). ID width IDW = clog2(NUM_REQ), derived locally.
- WIDTH, 4, code width in bits (>= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_mode  in  NUM_REQ  per-requester mode: 0 = binary->Gray, 1 = Gray->binary.
- req_data  in  NUM_REQ*WIDTH  packed operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  grant/accept, one-hot or zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  converted value.
- out_id  out  IDW  index of the requester that owns out_data.
- out_mode  out  1  mode of the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset state: IDLE, rr_ptr = 0, out_valid = 0, out_data = 0, out_id = 0, out_mode = 0, busy = 0, req_ready = 0. Internal iteration counter and operand registers are cleared.
  - rst has priority over every other event.
  - Reset in mid-operation discards the in-flight conversion; no out_valid is produced for it.
- States: IDLE, B2G, G2B, OUT.
- IDLE:
  - req_ready is combinational: one-hot at the first i with req_valid[i]=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... mod NUM_REQ). Zero if no requests.
  - Accept edge E0 (any grant) latches data, mode and id, and sets rr_ptr = (id+1) mod NUM_REQ.
  - Next state is B2G if mode = 0, else G2B.
  - Requesters must not drop req_valid or change data/mode before acceptance. req_valid must not depend on req_ready.
- B2G:
  - One cycle. Result = d ^ (d >> 1).
  - Goes to OUT at edge E0+1.
- G2B (serial, one bit per cycle):
  - At E0, res[WIDTH-1] = g[WIDTH-1] and k = WIDTH-2.
  - Each G2B cycle sets res[k] = res[k+1] ^ g[k], then decrements k.
  - After the k = 0 step (edge E0+WIDTH-1), goes to OUT.
  - Total G2B dwell is WIDTH-1 cycles.
- OUT:
  - out_valid = 1. out_data, out_id and out_mode are stable until handshake. req_ready stays 0.
  - On out_valid & out_ready: out_valid drops, state goes to IDLE.
  - No new grant in the handshake cycle; the earliest next accept is the cycle after.
- Latency, accept edge to out_valid high:
  - B2G: 1 cycle, out_valid visible after E0+1.
  - G2B: WIDTH-1 cycles.
- Throughput: one conversion per (latency + 2) cycles at best, with out_ready held high.
- Outputs in IDLE: out_data, out_id and out_mode hold their last values while out_valid = 0.
- Fairness:
  - A requester that keeps req_valid high is granted within NUM_REQ grants.
  - The pointer advances only on accept, never on idle cycles.
- Width rules: all XOR arithmetic is WIDTH bits; no carries. A round trip (B2G then G2B) is the identity.

Test Plan:
- Reset, then req0 mode=0 data=4'b1011.
  - Required: req_ready=4'b0001 in the accept cycle.
  - Required: out_valid rises 1 cycle later with out_data=4'b1110, out_id=0, out_mode=0, out_ready=1 → IDLE next cycle.
- req2 mode=1 data=4'b1110.
  - Required: busy for 3 G2B cycles, then out_valid with out_data=4'b1011 and out_id=2.
- All four req_valid high from reset, mode=0, data_i=i, out_ready=1.
  - Required grant order 0,1,2,3.
  - Required outputs 4'b0000, 4'b0001, 4'b0011, 4'b0010.
  - Required: rr_ptr wraps to 0.
- Backpressure: out_ready=0 for 5 cycles while req1 is pending.
  - Required: out_data and out_id held constant, req_ready=0 throughout.
  - Required: req1 accepted only in the cycle after the out handshake.
- rst pulsed during the second G2B cycle.
  - Required: next cycle state IDLE, out_valid=0, busy=0, rr_ptr=0.
  - Required: the aborted request is re-granted if still valid.
- Exhaustive sweep 0..15, both modes, from random requesters.
  - Required: out_data matches the reference XOR models.
  - Required: feeding B2G output back through G2B returns the original value.
  - Required: req_ready is never multi-hot.
